// File: rtl/uart_frame_parser.sv
// uart_frame_parser: frames UART bytes as SYNC ADDR LEN PAYLOAD CSUM,
// buffers and XOR-checks the payload, then replays it on a valid/ready
// byte stream tagged with the frame address.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   rx_data/rx_done       byte and one-cycle strobe from the UART receiver
//   rx_parity_err         parity flag qualifying the rx_done byte
//   m_data/m_addr/m_last  payload byte, frame address, last-byte marker
//   m_valid/m_ready       output handshake
//   busy                  parser is not idle
//   frame_ok, err_*       one-cycle result / error pulses
module uart_frame_parser #(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_parity_err,
  output logic [7:0] m_data,
  output logic [7:0] m_addr,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy,
  output logic       frame_ok,
  output logic       err_checksum,
  output logic       err_parity,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int IW =
    (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW =
    (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam bit TO_EN = (TIMEOUT_CLKS > 0);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] GAP_LAST =
    TO_EN ? TW'(TIMEOUT_CLKS - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_OUTPUT
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    wr_ptr_q, wr_ptr_d;
  logic [7:0]    rd_ptr_q, rd_ptr_d;
  logic [TW-1:0] gap_q, gap_d;
  logic          frame_ok_q, frame_ok_d;
  logic          err_checksum_q, err_checksum_d;
  logic          err_parity_q, err_parity_d;
  logic          err_len_q, err_len_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_overrun_q, err_overrun_d;

  logic [7:0] mem [MAX_LEN];
  logic       mem_we;
  logic       in_frame;
  logic       good_byte;
  logic       len_ok;
  logic       out_last;

  assign in_frame  = (state_q == S_ADDR) ||
                     (state_q == S_LEN) ||
                     (state_q == S_PAYLOAD) ||
                     (state_q == S_CSUM);
  assign good_byte = rx_done && !rx_parity_err;
  assign len_ok    = (rx_data != 8'd0) &&
                     (rx_data <= MAX_LEN_B);
  assign out_last  = (rd_ptr_q == len_q - 8'd1);

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    chk_d          = chk_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    frame_ok_d     = 1'b0;
    err_checksum_d = 1'b0;
    err_parity_d   = 1'b0;
    err_len_d      = 1'b0;
    err_timeout_d  = 1'b0;
    err_overrun_d  = 1'b0;
    mem_we         = 1'b0;

    // Gap counter only runs between bytes of a frame in progress.
    if (rx_done || !in_frame || !TO_EN) begin
      gap_d = '0;
    end else begin
      gap_d = gap_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (good_byte && rx_data == SYNC_BYTE) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (good_byte) begin
          addr_d  = rx_data;
          chk_d   = rx_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (good_byte) begin
          if (len_ok) begin
            len_d    = rx_data;
            chk_d    = chk_q ^ rx_data;
            wr_ptr_d = 8'd0;
            state_d  = S_PAYLOAD;
          end else begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (good_byte) begin
          mem_we   = 1'b1;
          chk_d    = chk_q ^ rx_data;
          wr_ptr_d = wr_ptr_q + 8'd1;
          if (wr_ptr_q == len_q - 8'd1) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (good_byte) begin
          if (rx_data == chk_q) begin
            frame_ok_d = 1'b1;
            rd_ptr_d   = 8'd0;
            state_d    = S_OUTPUT;
          end else begin
            err_checksum_d = 1'b1;
            state_d        = S_IDLE;
          end
        end
      end
      S_OUTPUT: begin
        // Input bytes cannot be buffered while replaying.
        if (rx_done) begin
          err_overrun_d = 1'b1;
        end
        if (m_ready) begin
          if (out_last) begin
            state_d = S_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Parity outranks length/checksum verdicts on the same byte.
    if (in_frame && rx_done && rx_parity_err) begin
      err_parity_d = 1'b1;
      state_d      = S_IDLE;
    end

    // A byte on the expiry cycle wins over the timeout.
    if (TO_EN && in_frame && !rx_done &&
        gap_q == GAP_LAST) begin
      err_timeout_d = 1'b1;
      state_d       = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      addr_q         <= 8'd0;
      len_q          <= 8'd0;
      chk_q          <= 8'd0;
      wr_ptr_q       <= 8'd0;
      rd_ptr_q       <= 8'd0;
      gap_q          <= '0;
      frame_ok_q     <= 1'b0;
      err_checksum_q <= 1'b0;
      err_parity_q   <= 1'b0;
      err_len_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overrun_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      chk_q          <= chk_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      gap_q          <= gap_d;
      frame_ok_q     <= frame_ok_d;
      err_checksum_q <= err_checksum_d;
      err_parity_q   <= err_parity_d;
      err_len_q      <= err_len_d;
      err_timeout_q  <= err_timeout_d;
      err_overrun_q  <= err_overrun_d;
    end
  end

  // Payload storage needs no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[IW-1:0]] <= rx_data;
    end
  end

  // Outputs derive from the state register so that
  // an async reset drops m_valid at once.
  assign busy         = (state_q != S_IDLE);
  assign m_valid      = (state_q == S_OUTPUT);
  assign m_last       = m_valid && out_last;
  assign m_data       = m_valid ?
                        mem[rd_ptr_q[IW-1:0]] : 8'd0;
  assign m_addr       = addr_q;
  assign frame_ok     = frame_ok_q;
  assign err_checksum = err_checksum_q;
  assign err_parity   = err_parity_q;
  assign err_len      = err_len_q;
  assign err_timeout  = err_timeout_q;
  assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: scoreboard bench for uart_frame_parser.
// Directed test-plan frames followed by randomized frame scenarios.
module tb_uart_frame_parser;

  localparam int         MAX_LEN = 16;
  localparam int         TO      = 50;
  localparam logic [7:0] SYNC    = 8'hA5;

  localparam logic [5:0] P_OK  = 6'b100000;
  localparam logic [5:0] P_CS  = 6'b010000;
  localparam logic [5:0] P_PAR = 6'b001000;
  localparam logic [5:0] P_LEN = 6'b000100;
  localparam logic [5:0] P_TO  = 6'b000010;
  localparam logic [5:0] P_OVR = 6'b000001;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_done = 1'b0;
  logic       rx_parity_err = 1'b0;
  logic [7:0] m_data, m_addr;
  logic       m_valid, m_last;
  logic       m_ready = 1'b1;
  logic       busy, frame_ok;
  logic       err_checksum, err_parity, err_len;
  logic       err_timeout, err_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int to_cyc   = -1;
  int ready_mode = 0;

  beat_t      exp_beats[$];
  logic [5:0] exp_pulses[$];

  uart_frame_parser #(
    .MAX_LEN(MAX_LEN),
    .SYNC_BYTE(SYNC),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .rx_parity_err(rx_parity_err),
    .m_data(m_data),
    .m_addr(m_addr),
    .m_valid(m_valid),
    .m_last(m_last),
    .m_ready(m_ready),
    .busy(busy),
    .frame_ok(frame_ok),
    .err_checksum(err_checksum),
    .err_parity(err_parity),
    .err_len(err_len),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows
  // a pulse or an accepted output beat.
  logic [5:0] pul;
  logic       stall_p = 1'b0;
  logic [7:0] pd, pa;
  logic       pl;

  always @(negedge clk) begin
    if (reset) begin
      stall_p = 1'b0;
    end else begin
      pul = {frame_ok, err_checksum, err_parity,
             err_len, err_timeout, err_overrun};
      if (pul != 6'd0) begin
        check("pulse_onehot", 32'($onehot(pul)), 1);
        if (pul[1]) to_cyc = cyc;
        if (pul[5]) check("ok_valid", m_valid, 1);
        if (exp_pulses.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pulse_extra: got %b expected none",
                   pul);
        end else begin
          check("pulse", pul, exp_pulses.pop_front());
        end
      end
      if (stall_p) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, pd);
        check("stall_addr", m_addr, pa);
        check("stall_last", m_last, pl);
      end
      if (m_valid && m_ready) begin
        if (exp_beats.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_extra: got %0h expected none",
                   m_data);
        end else begin
          check("beat", {m_addr, m_data, m_last},
                exp_beats.pop_front());
        end
      end
      stall_p = m_valid && !m_ready;
      pd = m_data;
      pa = m_addr;
      pl = m_last;
    end
  end

  // Reference model: a frame body is ADDR LEN PAYLOAD CSUM,
  // the checksum being the XOR of everything but SYNC.
  function automatic bq_t body(input logic [7:0] addr,
                               input bq_t pl_q);
    bq_t        b;
    logic [7:0] c;
    c = addr ^ 8'(pl_q.size());
    b.push_back(addr);
    b.push_back(8'(pl_q.size()));
    foreach (pl_q[i]) begin
      b.push_back(pl_q[i]);
      c = c ^ pl_q[i];
    end
    b.push_back(c);
    return b;
  endfunction

  function automatic bq_t rand_payload(input int n);
    bq_t p;
    for (int i = 0; i < n; i++)
      p.push_back(8'($urandom_range(0, 255)));
    return p;
  endfunction

  task automatic expect_good(input logic [7:0] addr,
                             input bq_t pl_q);
    beat_t bt;
    exp_pulses.push_back(P_OK);
    foreach (pl_q[i]) begin
      bt.addr = addr;
      bt.data = pl_q[i];
      bt.last = (i == pl_q.size() - 1);
      exp_beats.push_back(bt);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d,
                           input logic pe,
                           input int gap);
    rx_data = d;
    rx_parity_err = pe;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_parity_err = 1'b0;
    idle(gap);
  endtask

  // Sends SYNC then the first cnt bytes of b; parity
  // error on index perr (-1 for none).
  task automatic send_frame(input bq_t b, input int cnt,
                            input int perr, input int gmax);
    send_byte(SYNC, 1'b0, $urandom_range(0, gmax));
    for (int i = 0; i < cnt; i++)
      send_byte(b[i], 1'(i == perr),
                (i == cnt - 1) ? 0 :
                $urandom_range(0, gmax));
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      idle(1);
      k++;
    end
    check("idle_wait", busy, 0);
    idle(2);
  endtask

  task automatic stray();
    if ($urandom_range(0, 1) == 1) begin
      send_byte(SYNC, 1'b1, 1);
    end else begin
      send_byte(8'($urandom_range(0, 164)), 1'b0, 1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bq_t p, b;
    logic [7:0] a;
    int t0, kind, n;

    #2 reset = 1'b1;
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_addr", m_addr, 0);
    check("rst_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {frame_ok, err_checksum,
          err_parity, err_len, err_timeout,
          err_overrun}, 0);
    @(posedge clk);
    #1;
    idle(2);
    reset = 1'b0;
    idle(2);

    // Good frame A5 10 03 11 22 33 13.
    p = {8'h11, 8'h22, 8'h33};
    b = body(8'h10, p);
    check("model_csum", b[5], 8'h13);
    expect_good(8'h10, p);
    send_frame(b, b.size(), -1, 0);
    wait_idle(50);

    // Same frame, checksum 0x14.
    b[5] = 8'h14;
    exp_pulses.push_back(P_CS);
    send_frame(b, b.size(), -1, 0);
    wait_idle(10);

    // LEN 0x00 and 0x11, then a good frame.
    exp_pulses.push_back(P_LEN);
    send_frame({8'h10, 8'h00}, 2, -1, 0);
    wait_idle(10);
    exp_pulses.push_back(P_LEN);
    send_frame({8'h10, 8'h11}, 2, -1, 0);
    wait_idle(10);
    b = body(8'h10, p);
    expect_good(8'h10, p);
    send_frame(b, b.size(), -1, 1);
    wait_idle(50);

    // Parity on 2nd payload byte; stray 0x55 in IDLE.
    exp_pulses.push_back(P_PAR);
    send_frame(b, 4, 3, 0);
    wait_idle(10);
    send_byte(8'h55, 1'b0, 3);
    check("stray_busy", busy, 0);

    // Timeout after the ADDR byte.
    exp_pulses.push_back(P_TO);
    to_cyc = -1;
    send_byte(SYNC, 1'b0, 0);
    send_byte(8'h10, 1'b0, 0);
    t0 = cyc;
    idle(TO + 5);
    check("to_delay", 32'(to_cyc - t0), TO);
    check("to_busy", busy, 0);

    // Byte arriving on the expiry cycle is accepted.
    b = body(8'h20, p);
    expect_good(8'h20, p);
    send_byte(SYNC, 1'b0, 0);
    send_byte(b[0], 1'b0, TO - 1);
    for (int i = 1; i < b.size(); i++)
      send_byte(b[i], 1'b0, 0);
    wait_idle(50);

    // Stall 10 cycles with an overrun byte.
    ready_mode = 2;
    b = body(8'h10, p);
    expect_good(8'h10, p);
    exp_pulses.push_back(P_OVR);
    send_frame(b, b.size(), -1, 0);
    send_byte(SYNC, 1'b0, 0);
    idle(2);
    check("stall_m_data", m_data, 8'h11);
    check("stall_m_last", m_last, 0);
    idle(8);
    check("stall_m_data2", m_data, 8'h11);
    check("stall_m_addr", m_addr, 8'h10);
    ready_mode = 0;
    wait_idle(50);

    // Async reset in the middle of OUTPUT.
    ready_mode = 2;
    p = {8'hAB, 8'hCD};
    b = body(8'h42, p);
    exp_pulses.push_back(P_OK);
    send_frame(b, b.size(), -1, 0);
    idle(3);
    check("pre_rst_valid", m_valid, 1);
    #3 reset = 1'b1;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_data", m_data, 0);
    check("arst_addr", m_addr, 0);
    exp_beats.delete();
    exp_pulses.delete();
    ready_mode = 0;
    idle(2);
    reset = 1'b0;
    idle(2);

    // Randomized scenarios.
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 2) == 0) stray();
      a = 8'($urandom_range(0, 255));
      p = rand_payload($urandom_range(1, MAX_LEN));
      b = body(a, p);
      n = b.size();
      kind = $urandom_range(0, 6);
      case (kind)
        0, 1: begin
          ready_mode = $urandom_range(0, 1);
          expect_good(a, p);
          send_frame(b, n, -1, 3);
          wait_idle(200);
        end
        2: begin
          ready_mode = 2;
          expect_good(a, p);
          exp_pulses.push_back(P_OVR);
          send_frame(b, n, -1, 3);
          send_byte(8'($urandom_range(0, 255)), 1'b0, 0);
          idle($urandom_range(1, 10));
          ready_mode = $urandom_range(0, 1);
          wait_idle(200);
        end
        3: begin
          b[n-1] = b[n-1] ^
                   8'($urandom_range(1, 255));
          exp_pulses.push_back(P_CS);
          send_frame(b, n, -1, 3);
          wait_idle(10);
        end
        4: begin
          b[1] = ($urandom_range(0, 1) == 1) ? 8'd0 :
                 8'($urandom_range(MAX_LEN + 1, 255));
          exp_pulses.push_back(P_LEN);
          send_frame(b, 2, -1, 3);
          wait_idle(10);
        end
        5: begin
          t0 = $urandom_range(0, n - 1);
          exp_pulses.push_back(P_PAR);
          send_frame(b, t0 + 1, t0, 3);
          wait_idle(10);
        end
        default: begin
          exp_pulses.push_back(P_TO);
          send_frame(b, $urandom_range(0, n - 1), -1, 3);
          wait_idle(TO + 10);
        end
      endcase
    end

    ready_mode = 0;
    idle(5);
    check("beats_left", exp_beats.size(), 0);
    check("pulses_left", exp_pulses.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
